// File: rtl/transformer_job_scheduler_if.sv
// transformer_job_scheduler_if
// Job-request, weight-load and transformer-control signals of the scheduler.
// master: the scheduler side. slave: requesters, weight fetch and transformer.

interface transformer_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LAYER_W = 4,
    parameter int BEAT_AW = 8
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*LAYER_W-1:0] req_layer;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         ack;
    logic                       ack_err;
    logic                       busy;
    logic                       wl_valid;
    logic                       wl_ready;
    logic [BEAT_AW-1:0]         wl_addr;
    logic [LAYER_W-1:0]         wl_layer;
    logic                       tf_start;
    logic                       tf_done;

    modport master (
        input  req, req_layer, wl_ready, tf_done,
        output grant, ack, ack_err, busy, wl_valid, wl_addr, wl_layer, tf_start
    );

    modport slave (
        output req, req_layer, wl_ready, tf_done,
        input  grant, ack, ack_err, busy, wl_valid, wl_addr, wl_layer, tf_start
    );
endinterface

// File: rtl/transformer_job_scheduler.sv
// transformer_job_scheduler
// Round-robin scheduler sharing one transformer among NUM_REQ requesters.
// Per job: load the layer weights (skipped when that layer is already loaded),
// hold tf_start until tf_done, then pulse ack to the owner for one cycle.
// Optional RUN watchdog is built when SCHED_TIMEOUT_EN is defined.
//
// Weight-load handshake: a beat transfers on a rising edge where wl_valid and
// wl_ready are both high. Once raised, wl_valid stays high and wl_addr/wl_layer
// stay constant until that beat transfers; wl_ready may change freely.

module transformer_job_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int LAYER_W    = 4,
    parameter int LOAD_BEATS = 16,
    parameter int BEAT_AW    = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    transformer_job_scheduler_if.master bus,
    output logic [1:0]                  state_dbg
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]         state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] grant_q;
    logic [LAYER_W-1:0] owner_layer;
    logic [LAYER_W-1:0] cache_layer;
    logic               cache_valid;
    logic [BEAT_AW-1:0] beat;
    logic               run_timeout;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [LAYER_W-1:0] pick_layer;
    logic               pick_hit;

    // Round-robin search: first requester set at or after last+1, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_layer = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && bus.req[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(i);
                    pick_layer = bus.req_layer[i*LAYER_W +: LAYER_W];
                end
            end
        end
    end

    assign pick_hit = cache_valid && (pick_layer == cache_layer);

    // Job sequencing: arbitration, weight load, run, acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last        <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            grant_q     <= '0;
            owner_layer <= '0;
            cache_layer <= '0;
            cache_valid <= 1'b0;
            beat        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q     <= NUM_REQ'(1) << pick_idx;
                        owner       <= pick_idx;
                        owner_layer <= pick_layer;
                        beat        <= '0;
                        state       <= pick_hit ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.wl_ready) begin
                        if (beat == BEAT_AW'(LOAD_BEATS - 1)) begin
                            cache_layer <= owner_layer;
                            cache_valid <= 1'b1;
                            beat        <= '0;
                            state       <= S_RUN;
                        end else begin
                            beat <= beat + BEAT_AW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (bus.tf_done) begin
                        state <= S_ACK;
                    end else if (run_timeout) begin
                        // A hung job may have left the datapath weights in doubt
                        cache_valid <= 1'b0;
                        state       <= S_ACK;
                    end
                end
                default: begin
                    last    <= owner;
                    grant_q <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        err_flag;

    // tf_done on the expiry cycle takes precedence over the timeout
    assign run_timeout = (state == S_RUN) && (wd_cnt == 16'(TIMEOUT - 1)) && !bus.tf_done;

    // Watchdog counts RUN cycles; held at zero elsewhere so every RUN starts from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == S_RUN) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // Remember why RUN ended so the ACK cycle can report it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
        end else if (state == S_RUN) begin
            err_flag <= run_timeout;
        end
    end

    assign bus.ack_err = (state == S_ACK) && err_flag;
`else
    assign run_timeout = 1'b0;
    assign bus.ack_err = 1'b0;

    // TIMEOUT only sizes the watchdog; kept in the parameter list of both builds
    if (TIMEOUT < 2) begin : g_timeout_unused
    end
`endif

    assign bus.grant    = grant_q;
    assign bus.ack      = (state == S_ACK) ? grant_q : '0;
    assign bus.busy     = (state != S_IDLE);
    assign bus.wl_valid = (state == S_LOAD);
    assign bus.wl_addr  = (state == S_LOAD) ? beat : '0;
    assign bus.wl_layer = (state == S_LOAD) ? owner_layer : '0;
    assign bus.tf_start = (state == S_RUN);
    assign state_dbg    = state;
endmodule

// File: tb/tb_transformer_job_scheduler.sv
// tb_transformer_job_scheduler
// Directed jobs against a job-level model of the scheduler; every cycle the
// DUT outputs are compared with the model at the falling edge, and each job
// also has hand-computed expectations (beat counts, latencies, ack owners).

module tb_transformer_job_scheduler;
    localparam int NUM_REQ    = 4;
    localparam int LAYER_W    = 4;
    localparam int LOAD_BEATS = 16;
    localparam int BEAT_AW    = 8;
    localparam int TIMEOUT    = 8;
`ifdef SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state_dbg;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    transformer_job_scheduler_if #(.NUM_REQ(NUM_REQ), .LAYER_W(LAYER_W), .BEAT_AW(BEAT_AW)) bus ();

    transformer_job_scheduler #(
        .NUM_REQ(NUM_REQ), .LAYER_W(LAYER_W), .LOAD_BEATS(LOAD_BEATS),
        .BEAT_AW(BEAT_AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [NUM_REQ-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- responders: weight fetch and transformer ----------------
    int run_len     = 0;   // tf_done in this RUN cycle (1-based); 0 = never
    bit toggle_mode = 0;   // wl_ready alternates 1,0,1,0 during LOAD
    bit spurious    = 0;   // tf_done held high whenever tf_start is low
    int run_cnt;
    bit phase;

    initial begin
        bus.wl_ready = 1'b0;
        bus.tf_done  = 1'b0;
        run_cnt = 0;
        phase   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tf_start) run_cnt++;
            else run_cnt = 0;
            bus.tf_done = bus.tf_start ? (run_len != 0 && run_cnt == run_len) : spurious;
            if (!toggle_mode) begin
                bus.wl_ready = 1'b1;
            end else if (bus.wl_valid) begin
                bus.wl_ready = phase;
                phase = !phase;
            end else begin
                bus.wl_ready = 1'b0;
                phase = 1'b1;
            end
        end
    end

    // ---------------- job-level model ----------------
    logic [NUM_REQ-1:0] e_grant, e_ack;
    logic e_err, e_busy, e_wlv, e_tfs;
    logic [BEAT_AW-1:0] e_addr;
    logic [LAYER_W-1:0] e_layer;
    int m_last;
    bit m_cache_ok;
    int m_cache;

    task automatic m_out(input logic [NUM_REQ-1:0] g, input logic [NUM_REQ-1:0] a, input bit err,
                         input bit wlv, input int addr, input int lay, input bit tfs);
        e_grant = g;
        e_ack   = a;
        e_err   = err;
        e_busy  = (g != 0);
        e_wlv   = wlv;
        e_addr  = BEAT_AW'(addr);
        e_layer = LAYER_W'(lay);
        e_tfs   = tfs;
    endtask

    task automatic m_reset();
        m_last     = NUM_REQ - 1;
        m_cache_ok = 0;
        m_cache    = 0;
        m_out(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int m_pick(input logic [NUM_REQ-1:0] r, input int last_i);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (last_i + k) % NUM_REQ;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    initial begin : model
        int owner, lay, beat, n;
        bit hit, aborted, done, err;
        logic [NUM_REQ-1:0] g;
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_reset();
                continue;
            end
            owner = m_pick(bus.req, m_last);
            if (owner < 0) continue;
            lay = int'(bus.req_layer[owner*LAYER_W +: LAYER_W]);
            g = NUM_REQ'(1) << owner;
            aborted = 0;
            err = 0;
            hit = m_cache_ok && (m_cache == lay);
            if (!hit) begin
                beat = 0;
                while (!aborted && beat < LOAD_BEATS) begin
                    m_out(g, 0, 0, 1, beat, lay, 0);
                    @(posedge clk);
                    if (rst) aborted = 1;
                    else if (bus.wl_ready) beat++;
                end
                if (!aborted) begin
                    m_cache_ok = 1;
                    m_cache = lay;
                end
            end
            n = 0;
            done = 0;
            while (!aborted && !done) begin
                m_out(g, 0, 0, 0, 0, 0, 1);
                @(posedge clk);
                if (rst) aborted = 1;
                else if (bus.tf_done) done = 1;
                else if (TO_EN && n == TIMEOUT - 1) begin
                    done = 1;
                    err = 1;
                    m_cache_ok = 0;
                end
                n++;
            end
            if (!aborted) begin
                m_out(g, g, err, 0, 0, 0, 0);
                @(posedge clk);
                if (rst) aborted = 1;
                else begin
                    m_last = owner;
                    m_out(0, 0, 0, 0, 0, 0, 0);
                end
            end
            if (aborted) m_reset();
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        check("grant", bus.grant, e_grant);
        check("ack", bus.ack, e_ack);
        check("ack_err", bus.ack_err, e_err);
        check("busy", bus.busy, e_busy);
        check("wl_valid", bus.wl_valid, e_wlv);
        check("tf_start", bus.tf_start, e_tfs);
        if (e_wlv) begin
            check("wl_addr", bus.wl_addr, e_addr);
            check("wl_layer", bus.wl_layer, e_layer);
        end
    end

    // ---------------- monitor for hand-computed job expectations ----------------
    int n_beats, n_stall, n_tfs, n_acks, last_addr, t_tfs, t_grant, last_gap;
    int t_ack = -100;
    bit last_err;
    logic [NUM_REQ-1:0] prev_grant = '0;

    always @(negedge clk) begin
        if (bus.wl_valid && bus.wl_ready) begin
            n_beats++;
            last_addr = int'(bus.wl_addr);
        end
        if (bus.wl_valid && !bus.wl_ready) n_stall++;
        if (bus.tf_start) begin
            n_tfs++;
            if (t_tfs < 0) t_tfs = cyc;
        end
        if (bus.grant != 0 && prev_grant == 0) begin
            t_grant  = cyc;
            last_gap = cyc - t_ack;
        end
        prev_grant = bus.grant;
        if (bus.ack != 0) begin
            n_acks++;
            t_ack    = cyc;
            last_err = bus.ack_err;
            if (exp_q.size() == 0) check("ack_unexpected", bus.ack, 0);
            else check("ack_owner", bus.ack, exp_q.pop_front());
        end
    end

    task automatic clear_mon();
        n_beats = 0; n_stall = 0; n_tfs = 0; last_addr = -1; t_tfs = -1; t_grant = -1;
    endtask

    // ---------------- driver tasks ----------------
    int job_c0;

    task automatic cyc_wait();
        @(negedge clk);
        #1;
    endtask

    task automatic set_layer(input int i, input int v);
        bus.req_layer[i*LAYER_W +: LAYER_W] = LAYER_W'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cyc_wait();
        rst = 1'b0;
        cyc_wait();
    endtask

    // Single-requester job: raise req, drop it once granted, wait for the ack
    task automatic job(input logic [NUM_REQ-1:0] r, input int rlen);
        int k, start;
        clear_mon();
        run_len = rlen;
        start = n_acks;
        exp_q.push_back(r);
        bus.req = r;
        job_c0 = cyc;
        k = 0;
        while (bus.grant == 0 && k < 20) begin cyc_wait(); k++; end
        check("grant_seen", (bus.grant != 0), 1);
        bus.req = '0;
        k = 0;
        while (n_acks == start && k < 400) begin cyc_wait(); k++; end
        check("ack_seen", (n_acks != start), 1);
        cyc_wait();
    endtask

    // ---------------- directed tests ----------------
    int k, start;

    initial begin
        bus.req = '0;
        bus.req_layer = '0;
        repeat (2) cyc_wait();
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant, 0);
        rst = 1'b0;
        cyc_wait();

        // T1: first job, cold cache, layer 3
        set_layer(0, 3);
        job(4'b0001, 5);
        check("t1_grant_lat", t_grant - job_c0, 1);
        check("t1_beats", n_beats, 16);
        check("t1_last_addr", last_addr, 15);
        check("t1_run_entry", t_tfs - job_c0, 17);
        check("t1_tf_start_len", n_tfs, 5);
        check("t1_ack_err", last_err, 0);

        // T2: same layer again -> cache hit, no load
        job(4'b0001, 2);
        check("t2_beats", n_beats, 0);
        check("t2_run_entry", t_tfs - job_c0, 1);

        // T3: all requesting, distinct layers, round-robin from reset
        do_reset();
        set_layer(0, 5); set_layer(1, 6); set_layer(2, 7); set_layer(3, 8);
        clear_mon();
        run_len = 3;
        start = n_acks;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        bus.req = 4'b1111;
        k = 0;
        while (n_acks < start + 5 && k < 1000) begin cyc_wait(); k++; end
        bus.req = '0;
        check("t3_acks", n_acks - start, 5);
        check("t3_beats", n_beats, 80);
        check("t3_tf_start", n_tfs, 15);
        check("t3_gap", last_gap, 2);
        repeat (2) cyc_wait();

        // T4: wl_ready toggling, tf_done noise outside RUN
        toggle_mode = 1;
        spurious = 1;
        set_layer(2, 9);
        job(4'b0100, 2);
        check("t4_beats", n_beats, 16);
        check("t4_stalls", n_stall, 15);
        check("t4_run_entry", t_tfs - job_c0, 32);
        toggle_mode = 0;
        spurious = 0;

`ifdef SCHED_TIMEOUT_EN
        // T5: watchdog expiry, reload after error, done-at-expiry wins
        set_layer(1, 10);
        job(4'b0010, 0);
        check("t5_to_err", last_err, 1);
        check("t5_to_delay", t_ack - t_tfs, 8);
        job(4'b0010, 2);
        check("t5_reload_beats", n_beats, 16);
        check("t5_ok_err", last_err, 0);
        job(4'b0010, 8);
        check("t5_race_err", last_err, 0);
        check("t5_race_len", n_tfs, 8);
        job(4'b0010, 1);
        check("t5_hit_beats", n_beats, 0);
        check("t5_hit_entry", t_tfs - job_c0, 1);
`endif

        // T6: reset at beat 7 of a load
        clear_mon();
        run_len = 2;
        start = n_acks;
        set_layer(0, 11);
        bus.req = 4'b0001;
        k = 0;
        while (!(bus.wl_valid && bus.wl_addr == 8'd7) && k < 40) begin
            cyc_wait();
            if (bus.grant != 0) bus.req = '0;
            k++;
        end
        check("t6_reached_beat7", bus.wl_addr, 7);
        rst = 1'b1;
        #1;
        check("t6_rst_grant", bus.grant, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_wl_valid", bus.wl_valid, 0);
        repeat (2) cyc_wait();
        rst = 1'b0;
        repeat (3) cyc_wait();
        check("t6_no_ack", n_acks - start, 0);
        set_layer(0, 9);
        job(4'b0001, 1);
        check("t6_cache_cleared", n_beats, 16);
        set_layer(0, 11);
        job(4'b0001, 1);
        check("t6_full_load", n_beats, 16);
        job(4'b0001, 1);
        check("t6_then_hit", n_beats, 0);

        repeat (3) cyc_wait();
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/transformer_job_scheduler.md
# transformer_job_scheduler

Round-robin job scheduler that shares one transformer datapath among `NUM_REQ` requesters. For each granted job it loads the layer's weights, drives the transformer `start`/`done` handshake, and acknowledges the owning requester. Weights of the last loaded layer are tracked, so back-to-back jobs on the same layer skip the reload. It sits between the bus-side job registers and the `transformer_top` instance plus its weight-fetch unit.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `LAYER_W`, 4, width of the layer identifier
- `LOAD_BEATS`, 16, weight-load beats per layer (≥1)
- `BEAT_AW`, 8, width of `wl_addr` (2^BEAT_AW ≥ LOAD_BEATS)
- `TIMEOUT`, 1024, RUN-state watchdog limit in cycles (≥2, fits 16 bits)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  NUM_REQ  job request level per requester
- `req_layer`  in  NUM_REQ*LAYER_W  layer id per requester; slice i = [i*LAYER_W +: LAYER_W]
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle
- `ack`  out  NUM_REQ  one-cycle completion pulse to the owner
- `ack_err`  out  1  qualifies `ack`; 1 = job timed out
- `busy`  out  1  high in any state except IDLE
- `wl_valid`  out  1  weight-load beat request
- `wl_ready`  in  1  weight-fetch unit accepts the beat
- `wl_addr`  out  BEAT_AW  beat index, 0..LOAD_BEATS-1
- `wl_layer`  out  LAYER_W  layer being loaded
- `tf_start`  out  1  transformer start, a level held through RUN
- `tf_done`  in  1  transformer completion

## Operation
- States: IDLE, LOAD, RUN, ACK.
- IDLE: if any `req` bit is set, pick the first set bit searching upward from `last+1`, wrapping modulo NUM_REQ. Register `grant`, the owner index, and its layer.
  - Layer equals the cached layer and the cache is valid → RUN.
  - Otherwise → LOAD, with the beat counter at 0.
- LOAD: `wl_valid`=1, `wl_addr`=beat counter, `wl_layer`=owner layer. A beat completes on `wl_valid & wl_ready`.
  - When beat LOAD_BEATS-1 completes: cache ← owner layer, cache valid ← 1, → RUN.
- RUN: `tf_start`=1. When `tf_done`=1: → ACK with error flag 0.
- ACK: `ack[owner]`=1 and `ack_err`=error flag for exactly one cycle. `last` ← owner, `grant` ← 0, → IDLE.
- Requests are sampled only in IDLE. Dropping `req` mid-job does not abort the job; the ack is still issued.
- A requester still asserting `req` after its ack is re-arbitrated with lowest priority.
- `req` and `req_layer` must stay stable only in the cycle they are sampled.

## Timing
- Reset: state IDLE; `last`=NUM_REQ-1, so requester 0 wins first; cache invalid; beat and watchdog counters 0. All outputs are 0.
- `rst` asserted in any state aborts immediately: no ack is issued and the cache is invalidated.
- All outputs are registered or decoded from registered state only; there is no combinational path from input to output.
- Cycle timing (request seen in IDLE at cycle 0):
  - `grant`/`busy` high at cycle 1.
  - `wl_valid` high from cycle 1.
  - With `wl_ready`=1 throughout, RUN (`tf_start`) begins at cycle 1+LOAD_BEATS.
  - On a cache hit, RUN begins at cycle 1.
- `tf_done` sampled at cycle t → `ack` at t+1 → IDLE at t+2. Earliest next grant is t+3, so the minimum gap between jobs is 2 cycles.
- A `wl_ready` stall holds `wl_addr` and `wl_valid`.
- `tf_done` outside RUN is ignored.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A 16-bit watchdog clears on RUN entry and increments each RUN cycle.
  - At count TIMEOUT-1 without `tf_done`: → ACK with `ack_err`=1, cache invalidated.
  - `tf_done` in the same cycle as the expiry wins: no error.
- `SCHED_TIMEOUT_EN` undefined:
  - No watchdog logic; RUN waits indefinitely.
  - `ack_err` is tied to 0 and `TIMEOUT` is unused.

## Test plan
- Reset, then `req`=4'b0001, layer 3, `wl_ready`=1, `tf_done` 5 cycles into RUN → 16 beats with `wl_addr` 0..15, `tf_start` high for 5 cycles, `ack`=4'b0001, `ack_err`=0.
- Repeat the same layer 3 job → no `wl_valid`; `tf_start` at cycle 1 after the request.
- `req`=4'b1111 held, all jobs different layers → grant order 0,1,2,3,0, each preceded by a full LOAD.
- `wl_ready` toggling 1,0,1,0 during LOAD → `wl_addr` holds while stalled; exactly 16 accepted beats.
- `SCHED_TIMEOUT_EN`, TIMEOUT=8, `tf_done` never asserted → ack 8 cycles after RUN entry with `ack_err`=1; the next same-layer job reloads weights.
- `rst` pulsed mid-LOAD at beat 7 → all outputs 0 next edge, no ack; a subsequent same-layer job performs a full LOAD.
